// File: rtl/ex_elastic_stage.sv
// ex_elastic_stage: elastic pipeline register with 2-entry skid buffer, flush, step gating and stall counter
module ex_elastic_stage #(
  parameter int NB_DATA  = 128,
  parameter int NB_CTRL  = 16,
  parameter int NB_CNT   = 16,
  parameter bit NEG_EDGE = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_step,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [NB_CTRL-1:0] i_ctrl,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [1:0]         o_occupancy,
  output logic [NB_CNT-1:0]  o_stall_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state;
  logic [NB_DATA-1:0] main_data, skid_data;
  logic [NB_CTRL-1:0] main_ctrl, skid_ctrl;
  logic [NB_CNT-1:0] stall_cnt;
  logic clk_e, acc, emt;
  assign clk_e = NEG_EDGE ? ~i_clk : i_clk;
  always_comb begin
    o_ready = state != FULL;
    o_valid = state != EMPTY;
    o_data = main_data;
    o_ctrl = o_valid ? main_ctrl : '0;
    o_occupancy = state == FULL ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
    o_stall_count = stall_cnt;
    acc = i_valid & o_ready & i_step;
    emt = o_valid & i_ready & i_step;
  end
  always_ff @(posedge clk_e or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      stall_cnt <= '0;
    end else if (i_step) begin
      if (o_valid && !i_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (i_flush) state <= EMPTY;
      else case (state)
        EMPTY: if (acc) begin
          state <= ONE;
          main_data <= i_data;
          main_ctrl <= i_ctrl;
        end
        ONE: if (acc && emt) begin
          main_data <= i_data;
          main_ctrl <= i_ctrl;
        end else if (acc) begin
          state <= FULL;
          skid_data <= i_data;
          skid_ctrl <= i_ctrl;
        end else if (emt) state <= EMPTY;
        default: if (emt) begin
          state <= ONE;
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_elastic_stage.sv
// tb_ex_elastic_stage: randomized scoreboard bench for ex_elastic_stage against a queue-based model
`timescale 1ns/1ps
module tb_ex_elastic_stage;
  localparam int NB_DATA = 128;
  localparam int NB_CTRL = 16;
  localparam int NB_CNT = 4;
  localparam int CNT_MAX = (1 << NB_CNT) - 1;
  typedef struct {
    logic [NB_DATA-1:0] d;
    logic [NB_CTRL-1:0] c;
  } ent_t;
  logic i_clk = 1'b0, i_reset_n = 1'b0, i_step = 1'b1, i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  logic [NB_DATA-1:0] i_data = '0;
  logic [NB_CTRL-1:0] i_ctrl = '0;
  logic o_ready, o_valid;
  logic [NB_DATA-1:0] o_data;
  logic [NB_CTRL-1:0] o_ctrl;
  logic [1:0] o_occupancy;
  logic [NB_CNT-1:0] o_stall_count;
  int checks = 0, errors = 0;
  bit rst_evt = 1'b0;
  ent_t q[$];
  int sc = 0;
  ex_elastic_stage #(.NB_DATA(NB_DATA), .NB_CTRL(NB_CTRL), .NB_CNT(NB_CNT), .NEG_EDGE(1'b1)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_step(i_step), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_ctrl(i_ctrl),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_ctrl(o_ctrl),
    .o_occupancy(o_occupancy), .o_stall_count(o_stall_count)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string name, input logic [NB_DATA-1:0] act, input logic [NB_DATA-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic v, input logic [NB_DATA-1:0] d, input logic [NB_CTRL-1:0] c,
                     input logic r, input logic f, input logic s);
    @(posedge i_clk);
    #1;
    i_valid = v; i_data = d; i_ctrl = c; i_ready = r; i_flush = f; i_step = s;
  endtask
  // Model samples between the posedge and the falling active edge, when inputs are stable
  initial begin
    forever begin
      @(posedge i_clk);
      #2;
      if (!i_reset_n || rst_evt) begin
        if (!i_reset_n) begin
          chk("rst_valid", o_valid, 0);
          chk("rst_ready", o_ready, 1);
          chk("rst_data", o_data, 0);
          chk("rst_ctrl", o_ctrl, 0);
          chk("rst_occ", o_occupancy, 0);
          chk("rst_stall", o_stall_count, 0);
        end
        q.delete();
        sc = 0;
        rst_evt = 1'b0;
      end
      if (i_reset_n) begin
        chk("valid", o_valid, q.size() > 0);
        chk("ready", o_ready, q.size() < 2);
        chk("occupancy", o_occupancy, q.size());
        chk("ctrl", o_ctrl, q.size() > 0 ? q[0].c : '0);
        chk("stall_count", o_stall_count, sc);
        if (q.size() > 0) chk("data", o_data, q[0].d);
        if (i_step) begin
          if (q.size() > 0 && !i_ready && sc < CNT_MAX) sc++;
          if (q.size() > 0 && i_ready) void'(q.pop_front());
          if (i_flush) q.delete();
          else if (i_valid && o_ready && q.size() < 2) q.push_back('{i_data, i_ctrl});
        end
      end
    end
  end
  initial begin
    logic [NB_DATA-1:0] rd;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    i_reset_n = 1'b1;
    repeat (3) cyc(0, 0, 0, 1, 0, 1);
    for (int i = 1; i <= 4; i++) cyc(1, i, 16'h0100 + 16'(i), 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(1, 'hA, 16'h00AA, 1, 0, 1);
    cyc(1, 'hB, 16'h00BB, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(1, 'h11, 16'hFFFF, 0, 0, 1);
    cyc(1, 'h12, 16'hFFFF, 0, 0, 1);
    cyc(1, 'hC, 16'h00CC, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(1, 'h21, 16'h0021, 0, 0, 1);
    cyc(1, 'h22, 16'h0022, 0, 0, 1);
    repeat (5) cyc(1, 'h33, 16'h0033, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      cyc($urandom_range(0, 3) != 0, rd, 16'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 40) == 0, $urandom_range(0, 4) != 0);
    end
    cyc(1, 'h77, 16'h0077, 0, 0, 1);
    repeat (19) cyc(0, 0, 0, 0, 0, 1);
    @(posedge i_clk);
    #2;
    chk("stall_saturated", o_stall_count, CNT_MAX);
    #1;
    i_reset_n = 1'b0;
    rst_evt = 1'b1;
    #1;
    chk("async_valid", o_valid, 0);
    chk("async_ready", o_ready, 1);
    chk("async_data", o_data, 0);
    chk("async_ctrl", o_ctrl, 0);
    chk("async_occ", o_occupancy, 0);
    chk("async_stall", o_stall_count, 0);
    i_reset_n = 1'b1;
    for (int i = 0; i < 200; i++)
      cyc($urandom_range(0, 1) == 1, NB_DATA'($urandom), 16'($urandom), $urandom_range(0, 1) == 1, 0, 1);
    repeat (4) cyc(0, 0, 0, 1, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_elastic_stage.md
Name: ex_elastic_stage

Overview:
- Parametrised successor to the fixed ID/EX pipeline register: a generic elastic pipeline stage register with a 2-entry skid buffer.
- Uses valid/ready handshakes, debug single-step gating, flush, and bubble masking of control bits.
- Sits between any two pipeline stages (first use: ID->EX) and replaces hand-written per-stage latches.
- Also reports occupancy and a saturating stall counter for the debug unit.

Parameters:
- NB_DATA, 128, payload data bits (operands, immediates, pc4, register addresses); never masked.
- NB_CTRL, 16, control bits (reg_write, mem_write, branch, jump, halt...); forced to 0 whenever the output entry is not valid.
- NB_CNT, 16, stall counter width.
- NEG_EDGE, 1, 1 = state updates on falling edge of i_clk, 0 = rising edge.

Ports:
- i_clk  in  1  pipeline clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_step  in  1  debug step enable; 0 freezes all state except reset.
- i_flush  in  1  kill all buffered entries.
- i_valid  in  1  upstream entry valid.
- o_ready  out  1  stage can accept an entry.
- i_data  in  NB_DATA  upstream payload data.
- i_ctrl  in  NB_CTRL  upstream control bits.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts.
- o_data  out  NB_DATA  output payload data.
- o_ctrl  out  NB_CTRL  output control bits, masked by o_valid.
- o_occupancy  out  2  entries held (0..2).
- o_stall_count  out  NB_CNT  cycles with o_valid=1, i_ready=0, i_step=1.

Behaviour:
- Active edge: as selected by NEG_EDGE. Reset is asynchronous and active-low.
- Reset (i_reset_n=0), immediate regardless of clock:
  - state EMPTY; main and skid data/ctrl = 0.
  - o_valid=0, o_ready=1, o_data=0, o_ctrl=0, o_occupancy=0, o_stall_count=0.
- Handshakes:
  - Accept: acc = i_valid & o_ready & i_step.
  - Emit: emt = o_valid & i_ready & i_step.
- o_ready = (state != FULL). Decoded from registered state only; no combinational path from i_ready or i_valid.
- Outputs: o_valid = (state != EMPTY). o_data = main.data. o_ctrl = main.ctrl when o_valid, else 0.
- State machine (evaluated at the active edge; i_step=0 means no transition and no register update):
  - EMPTY: acc -> ONE, main<=in.
  - ONE:
    - acc&emt -> ONE, main<=in.
    - acc&!emt -> FULL, skid<=in.
    - emt&!acc -> EMPTY.
    - neither -> ONE.
  - FULL: emt -> ONE, main<=skid; otherwise hold. acc cannot occur (o_ready=0).
- Latency: 1 active edge from acceptance to o_valid when the stage is empty or draining.
- Throughput: 1 entry/cycle while i_ready=1.
- Ordering: entries are emitted strictly in acceptance order.
- Flush (i_flush=1 at an active edge with i_step=1):
  - state -> EMPTY; any simultaneous acc is dropped.
  - main/skid data keep their value (don't care); o_ctrl=0 from the next edge.
  - Flush takes priority over acc and emt. An emt in the same cycle still counts as transferred downstream, because the downstream samples that cycle.
- Flush with i_step=0 is ignored.
- Bubble: an EMPTY stage presents o_ctrl=0, so no register or memory write or branch is triggered. o_data holds its last value.
- o_occupancy: EMPTY=0, ONE=1, FULL=2.
- o_stall_count:
  - +1 per active edge with o_valid & !i_ready & i_step.
  - Saturates at 2^NB_CNT-1; no wrap.
  - Cleared only by reset; flush does not clear it.
- Reset asserted mid-transfer: both entries are lost, outputs go to reset values at once, no partial update.
- Simultaneous acc and emt in ONE: the new entry replaces main in the same edge, with no bubble.

Test Plan:
- Reset then idle: i_reset_n 0->1, no i_valid -> o_valid=0, o_ready=1, o_ctrl=0, o_occupancy=0, o_stall_count=0.
- Streaming: i_step=1, i_ready=1, i_valid=1 with data 1,2,3,4 on consecutive edges -> o_data 1,2,3,4 one edge later each, o_valid continuous, o_occupancy=1.
- Backpressure/skid: with ONE holding 0xA, drop i_ready and present 0xB -> FULL, o_ready=0, o_occupancy=2. Raise i_ready -> o_data 0xA then 0xB, no loss.
  - Stall count after 3 blocked edges = 3.
- Flush: FULL state with ctrl=0xFFFF, i_flush=1 and i_valid=1 with 0xC -> next edge o_valid=0, o_ctrl=0, o_occupancy=0; 0xC is never emitted.
- Step gating: i_step=0 for 5 edges with i_valid=1, i_ready=0, i_flush=1 -> no state, output or counter change. i_step=1 -> normal operation resumes.
- Saturation and async reset: NB_CNT=4, stalled 20 edges -> o_stall_count=15. Pulse i_reset_n low between edges -> all outputs 0 immediately, o_ready=1.
